// File: rtl/stream_mux_rr.sv
`default_nettype none
// ============================================================================
// Module      : stream_mux_rr
// Description : N-to-1 valid/ready stream multiplexer with a registered output.
//               Channel selection is either a fixed index (sel_i) or round-robin.
//               Optional macro STREAM_MUX_COUNT_EN adds a 32-bit transfer counter.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_mux_rr #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3
) (
    input  logic                      clk_i,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] data_i,
    input  logic [CHANNELS-1:0]       valid_i,
    output logic [CHANNELS-1:0]       ready_o,
    input  logic                      mode_i,
    input  logic [SEL_W-1:0]          sel_i,
    output logic [WIDTH-1:0]          data_o,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic [SEL_W-1:0]          grant_o
`ifdef STREAM_MUX_COUNT_EN
    ,
    output logic [31:0]               xfer_count_o
`endif
);

    localparam logic [SEL_W:0] c_channels = (SEL_W+1)'(CHANNELS);

    logic [WIDTH-1:0]    w_ch_data [CHANNELS];
    logic [SEL_W-1:0]    w_rr_idx;
    logic                w_rr_found;
    logic [SEL_W-1:0]    w_chosen;
    logic                w_has_choice;
    logic                w_load;
    logic                w_xfer;
    logic                w_sel_valid;
    logic [WIDTH-1:0]    w_sel_data;
    logic [CHANNELS-1:0] w_ready;

    logic [WIDTH-1:0]    r_data;
    logic                r_valid;
    logic [SEL_W-1:0]    r_grant;
    logic [SEL_W-1:0]    r_ptr;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_unpack
            assign w_ch_data[gi] = data_i[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Round-robin: the valid channel with the smallest distance past r_ptr wins.
    always_comb begin : p_rr_search
        int v_best;
        int v_dist;
        v_best   = CHANNELS;
        v_dist   = 0;
        w_rr_idx = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            v_dist = (c - int'(r_ptr) - 1 + CHANNELS) % CHANNELS;
            if (valid_i[c] && (v_dist < v_best)) begin
                v_best   = v_dist;
                w_rr_idx = SEL_W'(c);
            end
        end
        w_rr_found = (v_best < CHANNELS);
    end

    assign w_chosen     = mode_i ? w_rr_idx : sel_i;
    assign w_has_choice = mode_i ? w_rr_found : ({1'b0, sel_i} < c_channels);
    assign w_load       = !r_valid || ready_i;

    // Ready is computed from the choice alone, never from the chosen valid.
    always_comb begin : p_select
        w_ready     = '0;
        w_sel_data  = '0;
        w_sel_valid = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (w_chosen == SEL_W'(c)) begin
                w_sel_data  = w_ch_data[c];
                w_sel_valid = valid_i[c];
                w_ready[c]  = w_load && w_has_choice && rst_n;
            end
        end
    end

    assign w_xfer = w_load && w_has_choice && w_sel_valid;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_grant <= '0;
            r_ptr   <= SEL_W'(CHANNELS - 1);
        end else if (w_load) begin
            r_valid <= w_xfer;
            if (w_xfer) begin
                r_data  <= w_sel_data;
                r_grant <= w_chosen;
                r_ptr   <= w_chosen;
            end
        end
    end

`ifdef STREAM_MUX_COUNT_EN
    logic [31:0] r_xfer_count;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_xfer_count <= '0;
        end else if (w_xfer) begin
            r_xfer_count <= r_xfer_count + 32'd1;
        end
    end

    assign xfer_count_o = r_xfer_count;
`endif

    assign ready_o = w_ready;
    assign data_o  = r_data;
    assign valid_o = r_valid;
    assign grant_o = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_stream_mux_rr.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_mux_rr
// Description : Scoreboard bench for stream_mux_rr (8-channel and 6-channel builds).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_mux_rr;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  grant;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [255:0] data8;
    logic [7:0]   valid8;
    logic [7:0]   ready_o8;
    logic         mode8;
    logic [2:0]   sel8;
    logic [31:0]  data_o8;
    logic         valid_o8;
    logic         ready_i8;
    logic [2:0]   grant8;

    logic [5:0]   valid6;
    logic [5:0]   ready_o6;
    logic         mode6;
    logic [2:0]   sel6;
    logic [31:0]  data_o6;
    logic         valid_o6;
    logic         ready_i6;
    logic [2:0]   grant6;

`ifdef STREAM_MUX_COUNT_EN
    logic [31:0]  xfer_count8;
    logic [31:0]  xfer_count6;
`endif

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    stream_mux_rr #(.WIDTH(32), .CHANNELS(8), .SEL_W(3)) u_dut8 (
        .clk_i   (clk),
        .rst_n   (rst_n),
        .data_i  (data8),
        .valid_i (valid8),
        .ready_o (ready_o8),
        .mode_i  (mode8),
        .sel_i   (sel8),
        .data_o  (data_o8),
        .valid_o (valid_o8),
        .ready_i (ready_i8),
        .grant_o (grant8)
`ifdef STREAM_MUX_COUNT_EN
        ,
        .xfer_count_o (xfer_count8)
`endif
    );

    stream_mux_rr #(.WIDTH(32), .CHANNELS(6), .SEL_W(3)) u_dut6 (
        .clk_i   (clk),
        .rst_n   (rst_n),
        .data_i  (data8[191:0]),
        .valid_i (valid6),
        .ready_o (ready_o6),
        .mode_i  (mode6),
        .sel_i   (sel6),
        .data_o  (data_o6),
        .valid_o (valid_o6),
        .ready_i (ready_i6),
        .grant_o (grant6)
`ifdef STREAM_MUX_COUNT_EN
        ,
        .xfer_count_o (xfer_count6)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_base(input logic [31:0] base);
        for (int c = 0; c < 8; c++) data8[c*32 +: 32] = base + 32'(c) * 32'h11;
    endtask

    task automatic push(input logic [31:0] d, input logic [2:0] g);
        exp_t e;
        e.data  = d;
        e.grant = g;
        exp_q.push_back(e);
    endtask

    // Held word is discarded by reset, so pending expectations are dropped too.
    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        #2;
        check("rst_valid_o", valid_o8, 1'b0);
        check("rst_data_o", data_o8, 32'h0);
        check("rst_grant_o", grant8, 3'd0);
        check("rst_ready_o", ready_o8, 8'h00);
        valid8 = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    // Monitor: every accepted output word must match the head of the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && valid_o8 && ready_i8) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_unexpected: got data %0h grant %0d expected no word", data_o8, grant8);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_data", data_o8, e.data);
                    check("sb_grant", grant8, e.grant);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; mode8 = 1'b0; sel8 = 3'd3; valid8 = 8'hFF; ready_i8 = 1'b1;
        mode6 = 1'b0; sel6 = 3'd0; valid6 = 6'h00; ready_i6 = 1'b1;
        set_base(32'h0);
        #12;
        check("init_valid_o", valid_o8, 1'b0);
        check("init_data_o", data_o8, 32'h0);
        check("init_grant_o", grant8, 3'd0);
        check("init_ready_o", ready_o8, 8'h00);
        check("init_valid_o6", valid_o6, 1'b0);
        valid8 = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Fixed select of channel 3
        mode8 = 1'b0; sel8 = 3'd3; valid8 = 8'hFF; ready_i8 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push(32'h33, 3'd3);
            @(negedge clk);
            check("fixed_ready_o", ready_o8, 8'h08);
            step();
        end
        valid8 = 8'h00;
        step();

        // Round-robin from reset: 0..7 then 0
        do_reset();
        mode8 = 1'b1; valid8 = 8'hFF; ready_i8 = 1'b1;
        for (int g = 0; g < 9; g++) begin
            push(32'(g % 8) * 32'h11, 3'(g % 8));
            step();
        end
        // Only channels 0 and 7 valid, pointer at 0: alternate 7,0,7,0
        valid8 = 8'h81;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) push(32'h77, 3'd7);
            else            push(32'h00, 3'd0);
            step();
        end

        // Back-pressure: word from channel 5 must stay frozen
        mode8 = 1'b0; sel8 = 3'd5; valid8 = 8'hFF;
        push(32'h55, 3'd5);
        step();
        ready_i8 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sel8 = 3'(i); mode8 = i[0]; valid8 = 8'(i * 37 + 1);
            set_base(32'h2000 + 32'(i));
            @(negedge clk);
            check("stall_ready_o", ready_o8, 8'h00);
            check("stall_valid_o", valid_o8, 1'b1);
            check("stall_data_o", data_o8, 32'h55);
            check("stall_grant_o", grant8, 3'd5);
            step();
        end
        set_base(32'h1000);
        mode8 = 1'b0; sel8 = 3'd2; valid8 = 8'hFF; ready_i8 = 1'b1;
        push(32'h1022, 3'd2);
        step();
        valid8 = 8'h00;
        step();
        @(negedge clk);
        check("drain_valid_o", valid_o8, 1'b0);
        check("drain_data_hold", data_o8, 32'h1022);
        check("drain_grant_hold", grant8, 3'd2);
        step();

        // Pointer moved to 2 by the fixed-mode transfer, so round-robin picks 3
        mode8 = 1'b1; valid8 = 8'hFF;
        push(32'h1033, 3'd3);
        step();
        valid8 = 8'h00;
        step();

        // Reset while a word is held under back-pressure
        mode8 = 1'b0; sel8 = 3'd1; valid8 = 8'hFF; ready_i8 = 1'b0;
        push(32'h1011, 3'd1);
        step();
        valid8 = 8'hFF;
        do_reset();
        mode8 = 1'b1; valid8 = 8'h04; ready_i8 = 1'b0;
        push(32'h1022, 3'd2);
        step();
        valid8 = 8'h00; ready_i8 = 1'b1;
        step();
        step();

        // Six-channel build: out-of-range select accepts nothing
        mode6 = 1'b0; sel6 = 3'd2; valid6 = 6'h3F; ready_i6 = 1'b1;
        step();
        sel6 = 3'd7;
        @(negedge clk);
        check("ch6_ready_o_oob", ready_o6, 6'h00);
        check("ch6_valid_o", valid_o6, 1'b1);
        check("ch6_data_o", data_o6, 32'h1022);
        check("ch6_grant_o", grant6, 3'd2);
        step();
        @(negedge clk);
        check("ch6_drained", valid_o6, 1'b0);
        check("ch6_ready_o_idle", ready_o6, 6'h00);
        valid6 = 6'h00;
        step();

`ifdef STREAM_MUX_COUNT_EN
        do_reset();
        mode8 = 1'b1; valid8 = 8'hFF; ready_i8 = 1'b1;
        for (int g = 0; g < 10; g++) begin
            push(32'h1000 + 32'(g % 8) * 32'h11, 3'(g % 8));
            step();
        end
        valid8 = 8'h00;
        @(negedge clk);
        check("count_ten", xfer_count8, 32'd10);
        step();
        rst_n = 1'b0;
        #1;
        check("count_reset", xfer_count8, 32'd0);
        check("count_rst_valid", valid_o8, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
`endif

        step();
        check("sb_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stream_mux_rr.md
STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, data bits per channel.
REQ-002 The block SHALL have parameter CHANNELS, default 8, number of input channels, legal range 2..2**SEL_W.
REQ-003 The block SHALL have parameter SEL_W, default 3, width of the select and grant fields.
REQ-004 The block SHALL have port clk_i, input, 1, the only clock, rising-edge active.
REQ-005 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port data_i, input, CHANNELS*WIDTH, flattened channel data; channel c occupies bits [c*WIDTH +: WIDTH].
REQ-007 The block SHALL have port valid_i, input, CHANNELS, per-channel valid.
REQ-008 The block SHALL have port ready_o, output, CHANNELS, per-channel ready.
REQ-009 The block SHALL have port mode_i, input, 1: 0 = fixed select, 1 = round-robin.
REQ-010 The block SHALL have port sel_i, input, SEL_W, channel index used in fixed mode.
REQ-011 The block SHALL have port data_o, output, WIDTH, registered output data.
REQ-012 The block SHALL have port valid_o, output, 1, output register holds a word.
REQ-013 The block SHALL have port ready_i, input, 1, downstream accepts the word.
REQ-014 The block SHALL have port grant_o, output, SEL_W, index of the channel whose word is in data_o.

Function
REQ-015 The output register SHALL be able to load ("load") exactly when valid_o=0 or ready_i=1.
REQ-016 ready_o[c] SHALL be 1 only when load holds and c is the chosen channel; all other bits SHALL be 0; ready_o SHALL NOT depend on valid_i of the chosen channel.
REQ-017 Fixed mode: the chosen channel SHALL be sel_i; if sel_i >= CHANNELS, no channel SHALL be chosen and ready_o SHALL be all zeros.
REQ-018 Round-robin mode: the chosen channel SHALL be the first c with valid_i[c]=1, searching from pointer+1 upward and wrapping at CHANNELS-1 to 0; with no valid input, none is chosen.
REQ-019 A transfer on channel c SHALL occur when ready_o[c]=1 and valid_i[c]=1; on that edge data_o and grant_o SHALL load channel c's data and index and valid_o SHALL become 1.
REQ-020 On a load edge with no transfer, valid_o SHALL become 0; data_o and grant_o SHALL hold.
REQ-021 When valid_o=1 and ready_i=0, data_o, grant_o and valid_o SHALL hold unchanged regardless of inputs, mode or sel changes.
REQ-022 Latency from input transfer to valid_o SHALL be exactly 1 cycle; sustained throughput SHALL be 1 word per cycle when ready_i=1.
REQ-023 The round-robin pointer SHALL update to c only on a transfer from c, in either mode; a channel just granted SHALL have lowest priority next cycle.
REQ-024 Changing mode_i or sel_i SHALL take effect in the same cycle's chosen-channel computation; no word SHALL be lost or duplicated.

Reset
REQ-025 While rst_n=0: valid_o=0, data_o=0, grant_o=0, pointer=CHANNELS-1 (channel 0 highest priority first), ready_o all zeros.
REQ-026 Reset asserted mid-transfer SHALL discard the held word; after release the first load edge SHALL behave as from empty.

Configuration
REQ-027 With macro STREAM_MUX_COUNT_EN defined, the block SHALL add output xfer_count_o, 32 bits, reset to 0, incremented by 1 on each input transfer, wrapping from 0xFFFFFFFF to 0.
REQ-028 Without STREAM_MUX_COUNT_EN, the port and counter SHALL be absent and all other behaviour identical.

Verification
REQ-029 Fixed mode, sel_i=3, valid_i=8'hFF, ch3 data 0x33, ready_i=1 -> next cycle data_o=0x33, grant_o=3, ready_o=8'h08 every cycle.
REQ-030 Round-robin, valid_i=8'hFF constant, ready_i=1 after reset -> grant_o sequence 0,1,2,...,7,0 on consecutive cycles.
REQ-031 Round-robin, valid_i=8'b1000_0001, pointer after grant 7 -> next grant 0, then 7, alternating.
REQ-032 Word in output, ready_i=0 for 5 cycles while inputs change -> data_o, grant_o, valid_o=1 stable, ready_o=0; ready_i=1 -> next word loads same edge.
REQ-033 Fixed mode sel_i=7 with CHANNELS=6 -> ready_o=0, valid_o falls to 0 after drain.
REQ-034 With STREAM_MUX_COUNT_EN, 10 transfers then rst_n pulse -> xfer_count_o=10 then 0; valid_o=0 asynchronously.
